prime_stream_tx: RTL and testbench

PRIME_STREAM_TX -- requirements
Module: prime_stream_tx

---
 rtl/prime_stream_tx.sv | 124 ++++++++++++
 tb/tb_prime_stream_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/prime_stream_tx.sv
// Enumerates primes 2..limit by trial division (repeated subtraction) and streams them over valid/ready.
// Optional live prime_count when PRIME_STREAM_COUNT_EN is defined; otherwise prime_count is tied to 0.
module prime_stream_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] limit,
    output logic [7:0] prime_out,
    output logic       prime_valid,
    input  logic       prime_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] prime_count
);

    typedef enum logic [2:0] {
        IDLE,
        CAND,
        DIV_INIT,
        DIV_SUB,
        DIV_CHK,
        EMIT,
        FIN
    } state_t;

    state_t      state;
    logic [7:0]  lim_r;
    logic [8:0]  cand;
    logic [7:0]  div;
    logic [8:0]  rem;
    logic [15:0] div_sq;

    // 16-bit square so the termination test cannot overflow for any divisor
    assign div_sq = div * div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lim_r       <= '0;
            cand        <= '0;
            div         <= '0;
            rem         <= '0;
            prime_out   <= '0;
            prime_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lim_r <= limit;
                        cand  <= 9'd2;
                        busy  <= 1'b1;
                        state <= CAND;
                    end
                end
                CAND: begin
                    // cand is 9 bits so stepping past 255 still terminates
                    if (cand > {1'b0, lim_r}) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        div   <= 8'd2;
                        state <= DIV_INIT;
                    end
                end
                DIV_INIT: begin
                    if (div_sq > {7'd0, cand}) begin
                        prime_valid <= 1'b1;
                        prime_out   <= cand[7:0];
                        state       <= EMIT;
                    end else begin
                        rem   <= cand;
                        state <= DIV_SUB;
                    end
                end
                DIV_SUB: begin
                    if (rem >= {1'b0, div}) begin
                        rem <= rem - {1'b0, div};
                    end else begin
                        state <= DIV_CHK;
                    end
                end
                DIV_CHK: begin
                    if (rem == 9'd0) begin
                        cand  <= cand + 9'd1;
                        state <= CAND;
                    end else begin
                        div   <= div + 8'd1;
                        state <= DIV_INIT;
                    end
                end
                EMIT: begin
                    if (prime_ready) begin
                        prime_valid <= 1'b0;
                        cand        <= cand + 9'd1;
                        state       <= CAND;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRIME_STREAM_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_count <= '0;
        end else if (state == IDLE && start) begin
            prime_count <= '0;
        end else if (state == EMIT && prime_valid && prime_ready) begin
            prime_count <= prime_count + 8'd1;
        end
    end
`else
    assign prime_count = 8'd0;
`endif

endmodule

// File: tb/tb_prime_stream_tx.sv
// Directed bench for prime_stream_tx: reference primes queued at start, popped on each handshake.
module tb_prime_stream_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] limit = 8'd0;
    logic       prime_ready = 1'b0;
    logic [7:0] prime_out;
    logic       prime_valid;
    logic       busy;
    logic       done;
    logic [7:0] prime_count;

    int checks = 0;
    int failures = 0;

`ifdef PRIME_STREAM_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    prime_stream_tx dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .limit       (limit),
        .prime_out   (prime_out),
        .prime_valid (prime_valid),
        .prime_ready (prime_ready),
        .busy        (busy),
        .done        (done),
        .prime_count (prime_count)
    );

    always #5 clk = ~clk;

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d < n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // stall_at/stall_n: hold ready low for stall_n cycles when that prime is offered.
    // restart_at: re-pulse start (limit=3) at that cycle. abort_at: reset while that prime is offered.
    // done_cyc: if nonzero, required number of cycles from start to done.
    task automatic run(input logic [7:0] lim, input int exp_beats, input int stall_at,
                       input int stall_n, input int restart_at, input int abort_at,
                       input int done_cyc);
        int q[$];
        int beats = 0;
        int cyc = 0;
        int stalled = 0;
        int valid_seen = 0;
        int bad = 0;
        bit got_done = 1'b0;
        for (int c = 2; c <= int'(lim); c++) begin
            if (is_prime(c)) q.push_back(c);
        end
        @(negedge clk);
        limit = lim;
        start = 1'b1;
        prime_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_after_start", busy, 1);
        while (cyc < 60000) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (restart_at > 0 && cyc == restart_at) begin
                start = 1'b1;
                limit = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (prime_valid) valid_seen++;
            if (abort_at > 0 && prime_valid && int'(prime_out) == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_valid", prime_valid, 0);
                check("rst_out", prime_out, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_count", prime_count, 0);
                @(negedge clk);
                rst = 1'b0;
                prime_ready = 1'b1;
                repeat (40) begin
                    @(negedge clk);
                    if (prime_valid || busy || done) bad++;
                end
                check("idle_after_rst", bad, 0);
                return;
            end
            if (prime_valid && int'(prime_out) == stall_at && stalled == 0) stalled = 1;
            if (stalled >= 1 && stalled <= stall_n) begin
                check("stall_valid", prime_valid, 1);
                check("stall_out", prime_out, stall_at);
                prime_ready = 1'b0;
                stalled++;
            end else if (prime_valid) begin
                prime_ready = 1'b1;
                beats++;
                if (q.size() == 0) check("extra_beat", prime_out, 0);
                else check("beat", prime_out, q.pop_front());
            end else begin
                prime_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", got_done, 1);
        if (done_cyc > 0) check("done_latency", cyc, done_cyc);
        if (exp_beats == 0) check("no_valid", valid_seen, 0);
        check("beat_count", beats, exp_beats);
        check("queue_empty", q.size(), 0);
        check("prime_count", prime_count, CNT_EN ? exp_beats : 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_cleared", busy, 0);
        repeat (3) @(negedge clk);
        check("count_hold", prime_count, CNT_EN ? exp_beats : 0);
    endtask

    initial begin
        #1;
        check("reset_valid", prime_valid, 0);
        check("reset_out", prime_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_count", prime_count, 0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        run(8'd10, 4, 0, 0, 0, 0, 0);
        run(8'd1, 0, 0, 0, 0, 0, 2);
        run(8'd0, 0, 0, 0, 0, 0, 2);
        run(8'd255, 54, 0, 0, 0, 0, 0);
        run(8'd20, 8, 11, 5, 0, 0, 0);
        run(8'd50, 0, 0, 0, 0, 13, 0);
        run(8'd5, 3, 0, 0, 0, 0, 0);
        run(8'd30, 10, 0, 0, 20, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
